pc_sequencer: RTL and testbench

- Fetch-stage writer for the program counter. It computes and registers the next PC every cycle.
- Inputs that steer the next PC: stall (hazard unit, multdiv busy), branch/jump redirects from execute, and a halt.
- Drives the instruction-memory address and the PC+1 value consumed by the F/D latch.
- Flags bubble cycles so that downstream latches squash them.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/dffe_ref.sv | 19 +
 rtl/pc_incrementer.sv | 25 ++
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM state encoding and defaults.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALLED = 2'd2,
        ST_HALTED  = 2'd3
    } pc_state_t;

    localparam int PC_WIDTH_DEFAULT = 32;
    localparam int RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/dffe_ref.sv
// Single-bit enabled register with asynchronous active-high clear to a per-bit reset value.
module dffe_ref #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pc_incrementer.sv
// WIDTH-bit +1 adder as a half-adder ripple chain; the carry out of the top bit is dropped so the sum wraps.
import pc_sequencer_pkg::*;

module pc_incrementer #(
    parameter int WIDTH = PC_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_ha
            assign sum[i] = a[i] ^ carry[i];
            if (i > 0) begin : g_carry
                assign carry[i] = a[i-1] & carry[i-1];
            end
        end
    endgenerate

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter writer: FSM (BOOT/RUN/STALLED/HALTED) plus next-PC mux driving imem.
import pc_sequencer_pkg::*;

module pc_sequencer #(
    parameter int               WIDTH    = PC_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             halt,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus1,
    output logic             fetch_valid,
    output logic             flush,
    output logic [1:0]       state_out
);

    pc_state_t        state_q;
    pc_state_t        state_d;
    logic             fetch_valid_q;
    logic             fetch_valid_d;
    logic             pc_load;
    logic             take_redirect;
    logic [WIDTH-1:0] pc_d;

    pc_incrementer #(.WIDTH(WIDTH)) u_inc (
        .a   (pc_out),
        .sum (pc_plus1)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= ST_BOOT;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    // Priority halt > redirect > stall > increment applies identically in RUN and STALLED.
    always_comb begin
        state_d       = state_q;
        fetch_valid_d = fetch_valid_q;
        pc_load       = 1'b0;
        take_redirect = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end
            ST_RUN, ST_STALLED: begin
                if (halt) begin
                    state_d       = ST_HALTED;
                    fetch_valid_d = 1'b0;
                end else if (redirect_valid) begin
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                    pc_load       = 1'b1;
                    take_redirect = 1'b1;
                end else if (stall) begin
                    state_d       = ST_STALLED;
                    fetch_valid_d = 1'b1;
                end else begin
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                    pc_load       = 1'b1;
                end
            end
            ST_HALTED: begin
                state_d       = ST_HALTED;
                fetch_valid_d = 1'b0;
            end
            default: begin
                state_d       = ST_BOOT;
                fetch_valid_d = 1'b0;
            end
        endcase
    end

    assign pc_d = take_redirect ? redirect_target : pc_plus1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pc_reg
            dffe_ref #(.RST_VAL(RESET_PC[i])) u_pc_bit (
                .clk (clk),
                .clr (clr),
                .en  (pc_load),
                .d   (pc_d[i]),
                .q   (pc_out[i])
            );
        end
    endgenerate

    assign flush       = redirect_valid && ((state_q == ST_RUN) || (state_q == ST_STALLED));
    assign fetch_valid = fetch_valid_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random traffic against a behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic [31:0] pc_out;
    logic [31:0] pc_plus1;
    logic        fetch_valid;
    logic        flush;
    logic [1:0]  state_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: fetch address, valid flag and mode number 0..3 (boot, run, stalled, halted).
    logic [31:0] m_pc;
    logic        m_fv;
    int          m_mode;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .clr             (clr),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .pc_out          (pc_out),
        .pc_plus1        (pc_plus1),
        .fetch_valid     (fetch_valid),
        .flush           (flush),
        .state_out       (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pc_out"},      pc_out,             m_pc);
        check({tag, ".pc_plus1"},    pc_plus1,           m_pc + 32'd1);
        check({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_fv});
        check({tag, ".state"},       {30'd0, state_out}, 32'(m_mode));
    endtask

    // Apply inputs for one cycle, check flush, clock one edge, advance the model, check outputs.
    task automatic step(input string tag, input logic s, input logic rv,
                        input logic [31:0] rt, input logic h);
        logic exp_flush;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = rt;
        halt            = h;
        #1;
        exp_flush = rv && (m_mode == 1 || m_mode == 2);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_flush});
        @(posedge clk);
        #1;
        if (m_mode == 0) begin
            m_mode = 1;
            m_fv   = 1'b1;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (h) begin
                m_mode = 3;
                m_fv   = 1'b0;
            end else if (rv) begin
                m_pc   = rt;
                m_mode = 1;
                m_fv   = 1'b1;
            end else if (s) begin
                m_mode = 2;
                m_fv   = 1'b1;
            end else begin
                m_pc   = m_pc + 32'd1;
                m_mode = 1;
                m_fv   = 1'b1;
            end
        end
        check_outputs(tag);
    endtask

    // Pulse clr between clock edges and confirm the reset takes effect without an edge.
    task automatic pulse_clr(input string tag);
        clr = 1'b1;
        #1;
        m_pc   = 32'h0;
        m_fv   = 1'b0;
        m_mode = 0;
        check_outputs(tag);
        check({tag, ".flush"}, {31'd0, flush}, 32'd0);
        #1;
        clr = 1'b0;
        #1;
    endtask

    initial begin
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        halt            = 1'b0;
        clr             = 1'b1;
        m_pc            = 32'h0;
        m_fv            = 1'b0;
        m_mode          = 0;
        #12;
        check_outputs("reset");
        clr = 1'b0;
        #1;
        check_outputs("boot");

        // Reset and increment
        for (int i = 0; i < 5; i++) step("inc", 1'b0, 1'b0, 32'h0, 1'b0);
        check("inc.pc_is_4", pc_out, 32'd4);

        // Stall for three cycles, then release
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0, 1'b0);
        check("stall.pc_held", pc_out, 32'd4);
        check("stall.state", {30'd0, state_out}, 32'd2);
        step("unstall", 1'b0, 1'b0, 32'h0, 1'b0);
        check("unstall.pc", pc_out, 32'd5);

        // Redirect from pc 7
        step("run", 1'b0, 1'b0, 32'h0, 1'b0);
        step("run", 1'b0, 1'b0, 32'h0, 1'b0);
        check("run.pc_is_7", pc_out, 32'd7);
        step("redir", 1'b0, 1'b1, 32'h40, 1'b0);
        check("redir.pc", pc_out, 32'h40);
        step("redir_next", 1'b0, 1'b0, 32'hdead_beef, 1'b0);
        check("redir_next.pc", pc_out, 32'h41);

        // Redirect beats a simultaneous stall
        step("to9", 1'b0, 1'b1, 32'h9, 1'b0);
        step("redir_stall", 1'b1, 1'b1, 32'h100, 1'b0);
        check("redir_stall.pc", pc_out, 32'h100);
        check("redir_stall.state", {30'd0, state_out}, 32'd1);

        // Halt, then ignored redirect, then mid-cycle reset
        step("to20", 1'b0, 1'b1, 32'h20, 1'b0);
        step("halt", 1'b0, 1'b0, 32'h0, 1'b1);
        step("halted_redir", 1'b0, 1'b1, 32'h55, 1'b0);
        step("halted_stall", 1'b1, 1'b0, 32'h0, 1'b1);
        check("halted.pc", pc_out, 32'h20);
        check("halted.state", {30'd0, state_out}, 32'd3);
        pulse_clr("midclr");

        // Wrap-around
        step("wboot", 1'b0, 1'b0, 32'h0, 1'b0);
        step("wredir", 1'b0, 1'b1, 32'hffff_ffff, 1'b0);
        check("wrap.plus1", pc_plus1, 32'h0);
        step("wrap", 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap.pc", pc_out, 32'h0);

        // Random traffic; halts are escaped with a clr pulse
        for (int n = 0; n < 400; n++) begin
            logic s, rv, h;
            logic [31:0] rt;
            s  = ($urandom_range(0, 99) < 30);
            rv = ($urandom_range(0, 99) < 15);
            h  = ($urandom_range(0, 99) < 3);
            rt = ($urandom_range(0, 9) == 0) ? 32'hffff_ffff - 32'($urandom_range(0, 3)) : $urandom;
            step("rand", s, rv, rt, h);
            if (m_mode == 3 && $urandom_range(0, 3) == 0) pulse_clr("rand_clr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
